// File: rtl/agc_state_ctrl.sv
// AGC gain-sequencing controller: attack/hold/release FSM stepping a saturating gain word,
// configured over an Avalon-MM slave. Define AGC_STATE_CTRL_IRQ_EN to add the IRQ register and irq port.
module agc_state_ctrl #(
  parameter int DATA_W    = 16,
  parameter int HOLD_W    = 16,
  parameter int GAIN_W    = 8,
  parameter int GAIN_INIT = 128
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [2:0]        address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  input  logic              sample_valid,
  input  logic [DATA_W-1:0] sample_level,
  output logic [1:0]        state,
  output logic [GAIN_W-1:0] gain,
  output logic              gain_update
`ifdef AGC_STATE_CTRL_IRQ_EN
  ,
  output logic              irq
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_ATTACK  = 2'b01,
    ST_HOLD    = 2'b10,
    ST_RELEASE = 2'b11
  } state_t;

  localparam logic [GAIN_W-1:0] GAIN_RST = GAIN_W'(GAIN_INIT);
  localparam logic [GAIN_W-1:0] GAIN_MAX = {GAIN_W{1'b1}};

  logic              enable_q;
  logic [DATA_W-1:0] high_thr_q;
  logic [DATA_W-1:0] low_thr_q;
  logic [HOLD_W-1:0] hold_q;
  state_t            state_q, state_d;
  logic [GAIN_W-1:0] gain_q, gain_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic              gain_update_q;
  logic [31:0]       readdata_q, readdata_d;

  logic wr_s, soft_clr_s, level_high_s, level_low_s, run_s;

  assign wr_s         = chipselect & ~write_n;
  assign soft_clr_s   = wr_s & (address == 3'd0) & writedata[1];
  assign level_high_s = sample_level > high_thr_q;
  assign level_low_s  = sample_level < low_thr_q;
  assign run_s        = enable_q & sample_valid & ~soft_clr_s;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      enable_q   <= 1'b0;
      high_thr_q <= {DATA_W{1'b1}};
      low_thr_q  <= {DATA_W{1'b0}};
      hold_q     <= {HOLD_W{1'b0}};
    end else if (wr_s) begin
      case (address)
        3'd0:    enable_q   <= writedata[0];
        3'd1:    high_thr_q <= writedata[DATA_W-1:0];
        3'd2:    low_thr_q  <= writedata[DATA_W-1:0];
        3'd3:    hold_q     <= writedata[HOLD_W-1:0];
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      gain_q        <= GAIN_RST;
      hold_cnt_q    <= {HOLD_W{1'b0}};
      gain_update_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      gain_q        <= gain_d;
      hold_cnt_q    <= hold_cnt_d;
      gain_update_q <= (gain_d != gain_q);
    end
  end

  // Next state: HIGH test wins over every per-state rule
  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    if (soft_clr_s) begin
      state_d    = ST_IDLE;
      hold_cnt_d = {HOLD_W{1'b0}};
    end else if (!enable_q) begin
      state_d = ST_IDLE;
    end else if (!sample_valid) begin
      state_d = state_q;
    end else if (level_high_s) begin
      state_d = ST_ATTACK;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (level_low_s) begin
            state_d    = ST_HOLD;
            hold_cnt_d = hold_q;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_HOLD: begin
          if (!level_low_s) begin
            state_d = ST_IDLE;
          end else if (hold_cnt_q == {HOLD_W{1'b0}}) begin
            state_d = ST_RELEASE;
          end else begin
            hold_cnt_d = hold_cnt_q - HOLD_W'(1);
          end
        end
        ST_RELEASE: begin
          if (!level_low_s) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_RELEASE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    gain_d = gain_q;
    if (soft_clr_s) begin
      gain_d = GAIN_RST;
    end else if (run_s && level_high_s && (gain_q != {GAIN_W{1'b0}})) begin
      gain_d = gain_q - GAIN_W'(1);
    end else if (run_s && !level_high_s && level_low_s && (state_q == ST_RELEASE)
                 && (gain_q != GAIN_MAX)) begin
      gain_d = gain_q + GAIN_W'(1);
    end else begin
      gain_d = gain_q;
    end
  end

`ifdef AGC_STATE_CTRL_IRQ_EN
  logic mask_q, pending_q, irq_q;
  logic mask_d, pending_d;

  // Set beats write-1-to-clear when both land in one cycle
  always_comb begin
    mask_d    = mask_q;
    pending_d = pending_q;
    if (wr_s && (address == 3'd5)) begin
      mask_d = writedata[0];
      if (writedata[1]) begin
        pending_d = 1'b0;
      end else begin
        pending_d = pending_q;
      end
    end else begin
      mask_d = mask_q;
    end
    if ((state_d == ST_ATTACK) && (state_q != ST_ATTACK)) begin
      pending_d = 1'b1;
    end else begin
      pending_d = pending_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mask_q    <= 1'b0;
      pending_q <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      mask_q    <= mask_d;
      pending_q <= pending_d;
      irq_q     <= mask_d & pending_d;
    end
  end

  assign irq = irq_q;
`endif

  always_comb begin
    logic [31:0] gain_ext;
    logic [31:0] cnt_ext;
    gain_ext   = 32'(gain_q);
    cnt_ext    = 32'(hold_cnt_q);
    readdata_d = 32'd0;
    case (address)
      3'd0:    readdata_d = {31'd0, enable_q};
      3'd1:    readdata_d = 32'(high_thr_q);
      3'd2:    readdata_d = 32'(low_thr_q);
      3'd3:    readdata_d = 32'(hold_q);
      3'd4:    readdata_d = {cnt_ext[15:0], gain_ext[7:0], 6'd0, state_q};
`ifdef AGC_STATE_CTRL_IRQ_EN
      3'd5:    readdata_d = {30'd0, pending_q, mask_q};
`endif
      default: readdata_d = 32'd0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      readdata_q <= 32'd0;
    end else begin
      readdata_q <= readdata_d;
    end
  end

  assign readdata    = readdata_q;
  assign state       = state_q;
  assign gain        = gain_q;
  assign gain_update = gain_update_q;

endmodule

// File: tb/tb_agc_state_ctrl.sv
// Scoreboard bench for agc_state_ctrl: a behavioural model predicts every cycle's outputs,
// a monitor compares them one cycle later.
module tb_agc_state_ctrl;

  localparam int S_IDLE = 0, S_ATTACK = 1, S_HOLD = 2, S_RELEASE = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        sample_valid;
  logic [15:0] sample_level;
  logic [1:0]  state;
  logic [7:0]  gain;
  logic        gain_update;
  logic        irq;

  agc_state_ctrl #(.DATA_W(16), .HOLD_W(16), .GAIN_W(8), .GAIN_INIT(128)) dut (
    .clk(clk),
    .reset(reset),
    .address(address),
    .chipselect(chipselect),
    .write_n(write_n),
    .writedata(writedata),
    .readdata(readdata),
    .sample_valid(sample_valid),
    .sample_level(sample_level),
    .state(state),
    .gain(gain),
    .gain_update(gain_update)
`ifdef AGC_STATE_CTRL_IRQ_EN
    ,
    .irq(irq)
`endif
  );

`ifndef AGC_STATE_CTRL_IRQ_EN
  assign irq = 1'b0;
`endif

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [1:0]  st;
    logic [7:0]  g;
    logic        gu;
    logic [31:0] rd;
    logic        irq;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  // Reference model state
  int m_state, m_gain, m_cnt, m_high, m_low, m_hold;
  bit m_en, m_mask, m_pend;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    m_state = S_IDLE; m_gain = 128; m_cnt = 0;
    m_high = 16'hFFFF; m_low = 0; m_hold = 0;
    m_en = 1'b0; m_mask = 1'b0; m_pend = 1'b0;
  endtask

  function automatic logic [31:0] model_read(input logic [2:0] a);
    logic [31:0] cnt, gn;
    cnt = 32'(m_cnt);
    gn  = 32'(m_gain);
    case (a)
      3'd0: return {31'd0, m_en};
      3'd1: return 32'(m_high);
      3'd2: return 32'(m_low);
      3'd3: return 32'(m_hold);
      3'd4: return {cnt[15:0], gn[7:0], 6'd0, 2'(m_state)};
`ifdef AGC_STATE_CTRL_IRQ_EN
      3'd5: return {30'd0, m_pend, m_mask};
`endif
      default: return 32'd0;
    endcase
  endfunction

  // Drive one cycle of stimulus, advance the model, queue the expected outputs
  task automatic step(input logic [2:0] a, input logic cs, input logic wn, input logic [31:0] wd,
                      input logic sv, input logic [15:0] lvl);
    exp_t e;
    int ns, ng, nc;
    bit wr, clr, entered;
    address = a; chipselect = cs; write_n = wn; writedata = wd;
    sample_valid = sv; sample_level = lvl;
    wr  = cs && !wn;
    clr = wr && (a == 3'd0) && wd[1];
    e.rd = model_read(a);
    ns = m_state; ng = m_gain; nc = m_cnt;
    if (clr) begin
      ns = S_IDLE; ng = 128; nc = 0;
    end else if (!m_en) begin
      ns = S_IDLE;
    end else if (sv) begin
      if (int'(lvl) > m_high) begin
        ns = S_ATTACK;
        ng = (m_gain > 0) ? m_gain - 1 : 0;
      end else if (m_state == S_IDLE && int'(lvl) < m_low) begin
        ns = S_HOLD; nc = m_hold;
      end else if (m_state == S_HOLD && int'(lvl) < m_low) begin
        if (m_cnt == 0) ns = S_RELEASE;
        else nc = m_cnt - 1;
      end else if (m_state == S_RELEASE && int'(lvl) < m_low) begin
        ng = (m_gain < 255) ? m_gain + 1 : 255;
      end else begin
        ns = S_IDLE;
      end
    end
    entered = (ns == S_ATTACK) && (m_state != S_ATTACK);
`ifdef AGC_STATE_CTRL_IRQ_EN
    if (wr && a == 3'd5) begin
      m_mask = wd[0];
      if (wd[1]) m_pend = 1'b0;
    end
    if (entered) m_pend = 1'b1;
`endif
    if (wr) begin
      case (a)
        3'd0: m_en = wd[0];
        3'd1: m_high = int'(wd[15:0]);
        3'd2: m_low = int'(wd[15:0]);
        3'd3: m_hold = int'(wd[15:0]);
        default: ;
      endcase
    end
    e.gu  = (ng != m_gain);
    e.st  = 2'(ns);
    e.g   = 8'(ng);
    e.irq = m_mask & m_pend;
    m_state = ns; m_gain = ng; m_cnt = nc;
    exp_q.push_back(e);
    @(posedge clk);
    #2;
  endtask

  task automatic wr_reg(input logic [2:0] a, input logic [31:0] d);
    step(a, 1'b1, 1'b0, d, 1'b0, 16'd0);
  endtask

  task automatic smp(input logic [15:0] lvl);
    step(3'd4, 1'b1, 1'b1, 32'd0, 1'b1, lvl);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    address = 3'd0; chipselect = 1'b0; write_n = 1'b1; writedata = 32'd0;
    sample_valid = 1'b0; sample_level = 16'd0;
    exp_q.delete();
    model_reset();
    #1;
    chk("reset_state", 32'(state), 32'd0);
    chk("reset_gain", 32'(gain), 32'd128);
    chk("reset_readdata", readdata, 32'd0);
    chk("reset_gain_update", 32'(gain_update), 32'd0);
    @(posedge clk);
    @(posedge clk);
    #2;
    reset = 1'b0;
  endtask

  // Monitor: compare DUT outputs against the oldest queued expectation
  always @(posedge clk) begin
    #1;
    if (!reset && exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      chk("state", 32'(state), 32'(mon_e.st));
      chk("gain", 32'(gain), 32'(mon_e.g));
      chk("gain_update", 32'(gain_update), 32'(mon_e.gu));
      chk("readdata", readdata, mon_e.rd);
`ifdef AGC_STATE_CTRL_IRQ_EN
      chk("irq", 32'(irq), 32'(mon_e.irq));
`endif
    end
  end

  initial begin
    int guard;
    logic [31:0] wd;
    #2;
    do_reset();

    // Config reset values
    step(3'd1, 1'b1, 1'b1, 32'd0, 1'b0, 16'd0);
    step(3'd2, 1'b1, 1'b1, 32'd0, 1'b0, 16'd0);
    wr_reg(3'd1, 32'd1000);
    wr_reg(3'd2, 32'd100);
    wr_reg(3'd0, 32'd1);

    // Attack, then back to IDLE
    repeat (3) smp(16'd2000);
    smp(16'd500);

    // Hold and release
    wr_reg(3'd3, 32'd2);
    repeat (5) smp(16'd50);
    smp(16'd500);

    // Climb to gain 254 in RELEASE, then hit the saturation rail
    repeat (4) smp(16'd50);
    guard = 0;
    while (m_gain < 254 && guard < 300) begin
      smp(16'd50);
      guard++;
    end
    repeat (3) smp(16'd50);
    smp(16'd500);

    // HIGH write with a concurrent sample uses the old threshold
    step(3'd1, 1'b1, 1'b0, 32'd10, 1'b1, 16'd500);
    smp(16'd500);
    // soft_clear overrides the concurrent sample
    step(3'd0, 1'b1, 1'b0, 32'd3, 1'b1, 16'd2000);
    step(3'd4, 1'b1, 1'b1, 32'd0, 1'b0, 16'd0);

`ifdef AGC_STATE_CTRL_IRQ_EN
    wr_reg(3'd5, 32'd1);
    smp(16'd2000);
    step(3'd5, 1'b1, 1'b1, 32'd0, 1'b0, 16'd0);
    wr_reg(3'd5, 32'd2);
    step(3'd5, 1'b1, 1'b1, 32'd0, 1'b0, 16'd0);
    step(3'd5, 1'b1, 1'b1, 32'd0, 1'b0, 16'd0);
`endif

    // Disable mid-attack
    smp(16'd2000);
    wr_reg(3'd0, 32'd0);
    smp(16'd2000);
    smp(16'd2000);

    // Reset in mid-operation
    wr_reg(3'd0, 32'd1);
    smp(16'd2000);
    do_reset();

    // Randomized traffic
    wr_reg(3'd1, 32'd1500);
    wr_reg(3'd2, 32'd600);
    wr_reg(3'd0, 32'd1);
    for (int i = 0; i < 1500; i++) begin
      logic [2:0] a;
      logic cs, wn;
      a  = 3'($urandom_range(0, 7));
      cs = ($urandom_range(0, 9) != 0);
      wn = ($urandom_range(0, 9) != 0);
      case (a)
        3'd0: wd = {30'd0, ($urandom_range(0, 19) == 0), ($urandom_range(0, 9) != 0)};
        3'd1: wd = 32'($urandom_range(200, 3000)) | 32'hABCD_0000;
        3'd2: wd = 32'($urandom_range(0, 1600));
        3'd3: wd = 32'($urandom_range(0, 3));
        default: wd = $urandom;
      endcase
      if (!(cs && !wn) || a != 3'd0) begin
        if (!m_en && $urandom_range(0, 3) == 0) begin
          a = 3'd0; cs = 1'b1; wn = 1'b0; wd = 32'd1;
        end
      end
      step(a, cs, wn, wd, ($urandom_range(0, 3) != 0), 16'($urandom_range(0, 3500)));
    end
    step(3'd4, 1'b0, 1'b1, 32'd0, 1'b0, 16'd0);
    #10;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/agc_state_ctrl.md
Name: agc_state_ctrl

Overview:
- Gain-sequencing controller for the audio AGC path.
- Consumes a per-sample envelope level and runs a 4-state attack/hold/release FSM that steps a saturating gain word.
- Exports the 2-bit FSM state to the Nios II 2-bit state input PIO and the gain word to the gain multiplier.
- Thresholds and hold time are configured over an Avalon-MM slave with registered readdata (read latency 1).

Parameters:
- DATA_W, 16, width of sample_level and both threshold registers.
- HOLD_W, 16, width of hold counter and HOLD register.
- GAIN_W, 8, width of gain output.
- GAIN_INIT, 128, gain value after reset or soft clear.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- address  in  3  Avalon register select.
- chipselect  in  1  Avalon slave select.
- write_n  in  1  Avalon write strobe, active-low; a write occurs when chipselect=1 and write_n=0.
- writedata  in  32  Avalon write data.
- readdata  out  32  registered read data.
- sample_valid  in  1  one-cycle qualifier for sample_level.
- sample_level  in  DATA_W  unsigned envelope magnitude.
- state  out  2  FSM state, wired to the state PIO in_port.
- gain  out  GAIN_W  current gain word.
- gain_update  out  1  one-cycle pulse on the cycle after gain changes.

Behaviour:
- Register map (word addresses):
  - 0 CTRL: bit0 enable (R/W, reset 0); bit1 soft_clear (write-1, self-clearing, reads 0).
  - 1 HIGH_THR: [DATA_W-1:0], reset all-ones.
  - 2 LOW_THR: [DATA_W-1:0], reset 0.
  - 3 HOLD: [HOLD_W-1:0], reset 0.
  - 4 STATUS (RO): [1:0] state, [15:8] gain (zero-extended or truncated to GAIN_W), [31:16] hold counter (low 16 bits).
  - Other addresses read 0; writes to them are ignored.
- Read timing: readdata updates every clock with the mux output for the current address; value is 0 when address is unmapped. Reset value 0.
- Write timing: a register write takes effect the cycle after the write. A sample in the write cycle uses the old values.
- State encoding: IDLE=00, ATTACK=01, HOLD=10, RELEASE=11.
- FSM transitions are evaluated only on cycles with sample_valid=1. Comparisons are unsigned, and the HIGH test has priority.
- IDLE:
  - level>HIGH -> ATTACK.
  - level<LOW -> HOLD, and load hold_cnt=HOLD.
  - Otherwise stay in IDLE.
- ATTACK:
  - level>HIGH -> stay in ATTACK, gain-=1 (saturates at 0).
  - Otherwise -> IDLE.
  - The entry sample itself also decrements gain.
- HOLD:
  - level>HIGH -> ATTACK.
  - level>=LOW -> IDLE.
  - Otherwise, if hold_cnt==0 -> RELEASE; else hold_cnt-=1.
  - HOLD=0 means the second consecutive low sample enters RELEASE.
- RELEASE:
  - level>HIGH -> ATTACK.
  - level>=LOW -> IDLE.
  - Otherwise gain+=1 (saturates at 2^GAIN_W-1).
- Misconfiguration (LOW>HIGH): needs no special handling; HIGH priority resolves it.
- gain_update: asserted for one cycle the cycle after gain changes value. It is not asserted when gain stays pinned at saturation.
- enable=0 behaviour:
  - State forced to IDLE on the next cycle; samples are ignored.
  - gain is held, and hold_cnt is held.
  - Clearing enable mid-ATTACK/HOLD/RELEASE returns to IDLE with no gain change.
- soft_clear: the next cycle forces state=IDLE, gain=GAIN_INIT, hold_cnt=0. It overrides any sample in the same cycle and does not change enable or the config registers.
- Reset values:
  - state=IDLE, gain=GAIN_INIT, hold_cnt=0, gain_update=0, readdata=0.
  - Config registers take the reset values above.

Optional Feature:
- Macro: AGC_STATE_CTRL_IRQ_EN.
- When defined:
  - Adds output port irq (1 bit).
  - Adds register 5 IRQ: bit0 mask (R/W, reset 0), bit1 pending.
  - pending sets on any transition into ATTACK and is write-1-to-clear. If set and clear occur in the same cycle, set wins.
  - irq = mask & pending, registered, reset 0.
- When undefined: no irq port; address 5 reads 0 and writes to it are ignored.

Test Plan:
- Reset and config:
  - Assert reset mid-operation -> state=00, gain=128, readdata=0.
  - Read addr1 -> 0x0000FFFF, read addr2 -> 0.
- Attack:
  - Setup: enable=1, HIGH=1000, LOW=100.
  - Stimulus: three samples of 2000.
  - Expect: state=01 after the first; gain 127,126,125; three gain_update pulses.
- Hold and release:
  - Setup: HOLD=2.
  - Stimulus: five samples of 50.
  - Expect: HOLD after sample 1, RELEASE after sample 4, gain+1 on sample 5.
  - Then one sample of 500 -> IDLE.
- Saturation:
  - Setup: gain=254.
  - Stimulus: RELEASE with three low samples.
  - Expect: gain=255, gain_update pulses once only.
- Simultaneous events:
  - HIGH write to 10 in the same cycle as sample 500 -> no ATTACK; the next sample 500 -> ATTACK.
  - soft_clear together with sample 2000 -> state=00, gain=128.
- IRQ (macro defined):
  - Setup: mask=1.
  - Stimulus: sample 2000.
  - Expect: pending=1, irq=1.
  - Write 0x2 to addr5 -> irq=0 on the following cycle.
